// File: rtl/ddr3_rd_control.sv
// ddr3_rd_control: pops fill headers and streams sequential MIG burst reads into the readout FIFO.
// Define DDR3_RD_HDR_FWD_EN to forward each fill header into the readout FIFO ahead of its data.
module ddr3_rd_control #(
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         readout_enabled,
    input  logic [127:0] fill_header_rd_dat,
    input  logic         fill_header_fifo_empty,
    output logic         fill_header_rd_en,
    output logic         rd_app_en,
    input  logic         rd_app_rdy,
    output logic [25:0]  ddr3_rd_addr,
    input  logic [127:0] app_rd_data,
    input  logic         app_rd_data_valid,
    output logic [127:0] ddr3_rd_fifo_dat,
    output logic         ddr3_rd_fifo_wr_en,
    input  logic         ddr3_rd_fifo_almost_full,
    output logic         ddr3_rd_busy,
    output logic         ddr3_rd_done,
    output logic         ddr3_rd_err
);
`ifdef DDR3_RD_HDR_FWD_EN
    typedef enum logic [2:0] {IDLE, LOAD, HDR_FWD, READ, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, READ, DONE} state_t;
`endif
    localparam logic [5:0] MAX_OUT = 6'(MAX_OUTSTANDING);
    state_t r_state, w_next;
    logic [22:0]  r_addr_gen;
    logic [23:0]  r_addr_cntr, r_burst_cntr;
    logic [5:0]   r_outstanding;
    logic         r_hold, r_err, r_wr_en;
    logic [127:0] r_dat, w_hdr;
    logic         w_accept, w_spurious, w_take, w_hdr_wr;
`ifdef DDR3_RD_HDR_FWD_EN
    logic [127:0] r_hdr;
    always_ff @(posedge clk) begin
        if (reset)
            r_hdr <= '0;
        else if (r_state == LOAD)
            r_hdr <= fill_header_rd_dat;
    end
    assign w_hdr    = r_hdr;
    assign w_hdr_wr = r_state == HDR_FWD && readout_enabled && !ddr3_rd_fifo_almost_full;
`else
    logic w_unused;
    assign w_unused = ^{fill_header_rd_dat[127:76], fill_header_rd_dat[52:23]};
    assign w_hdr    = '0;
    assign w_hdr_wr = 1'b0;
`endif
    assign w_accept   = rd_app_en && rd_app_rdy;
    // MIG data cannot be stalled, so anything unaccounted for is dropped and flagged
    assign w_spurious = app_rd_data_valid && (r_outstanding == 0 || (r_state == READ && r_burst_cntr == 0));
    assign w_take     = app_rd_data_valid && !w_spurious && r_state == READ;

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state != IDLE && !readout_enabled)
            w_next = IDLE;
        else
            case (r_state)
                IDLE:    w_next = (readout_enabled && !fill_header_fifo_empty && r_outstanding == 0) ? LOAD : IDLE;
`ifdef DDR3_RD_HDR_FWD_EN
                LOAD:    w_next = HDR_FWD;
                HDR_FWD: w_next = ddr3_rd_fifo_almost_full ? HDR_FWD : (r_burst_cntr == 0 ? DONE : READ);
`else
                LOAD:    w_next = fill_header_rd_dat[22:0] == 0 ? DONE : READ;
`endif
                READ:    w_next = r_burst_cntr == 0 ? DONE : READ;
                DONE:    w_next = IDLE;
                default: w_next = IDLE;
            endcase
    end

    // A raised request is held until accepted even if almost_full rises meanwhile
    always_comb begin
        fill_header_rd_en  = r_state == LOAD;
        ddr3_rd_done       = r_state == DONE;
        ddr3_rd_busy       = r_state != IDLE || r_outstanding != 0;
        rd_app_en          = r_state == READ && readout_enabled && r_addr_cntr != 0 &&
                             (r_hold || (r_outstanding < MAX_OUT && !ddr3_rd_fifo_almost_full));
        ddr3_rd_addr       = {r_addr_gen, 3'b000};
        ddr3_rd_fifo_dat   = r_dat;
        ddr3_rd_fifo_wr_en = r_wr_en;
        ddr3_rd_err        = r_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_gen    <= '0;
            r_addr_cntr   <= '0;
            r_burst_cntr  <= '0;
            r_outstanding <= '0;
            r_hold        <= 1'b0;
            r_err         <= 1'b0;
            r_wr_en       <= 1'b0;
            r_dat         <= '0;
        end else begin
            r_hold  <= rd_app_en && !rd_app_rdy;
            r_err   <= r_err || w_spurious;
            r_wr_en <= w_take || w_hdr_wr;
            if (w_take || w_hdr_wr)
                r_dat <= w_hdr_wr ? w_hdr : app_rd_data;
            if (w_accept && !app_rd_data_valid)
                r_outstanding <= r_outstanding + 6'd1;
            else if (!w_accept && app_rd_data_valid && r_outstanding != 0)
                r_outstanding <= r_outstanding - 6'd1;
            if (r_state == LOAD) begin
                r_addr_gen   <= fill_header_rd_dat[75:53];
                r_addr_cntr  <= {1'b0, fill_header_rd_dat[22:0]};
                r_burst_cntr <= {1'b0, fill_header_rd_dat[22:0]};
            end else begin
                if (w_accept) begin
                    r_addr_gen  <= r_addr_gen + 23'd1;
                    r_addr_cntr <= r_addr_cntr - 24'd1;
                end
                if (w_take)
                    r_burst_cntr <= r_burst_cntr - 24'd1;
            end
        end
    end
endmodule
